// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings, mesh port IDs and route-mode selectors.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    localparam int unsigned PORT_RESOURCE = 0;
    localparam int unsigned PORT_LEFT     = 1;
    localparam int unsigned PORT_NORTH    = 2;
    localparam int unsigned PORT_RIGHT    = 3;
    localparam int unsigned PORT_SOUTH    = 4;
    localparam int unsigned PORT_NUM      = 5;
    localparam int unsigned PORT_ID_W     = 3;

    localparam int unsigned ROUTE_XY = 0;
    localparam int unsigned ROUTE_YX = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } rt_state_e;

endpackage

// File: rtl/dor_route_calc.sv
// Combinational dimension-order route decode: destination coordinates to one-hot output port.
module dor_route_calc
    import noc_pkg::*;
#(
    parameter int unsigned COL_CORD   = 0,
    parameter int unsigned ROW_CORD   = 0,
    parameter int unsigned COL_ADDR_W = 4,
    parameter int unsigned ROW_ADDR_W = 4,
    parameter int unsigned OUT_M      = 5,
    parameter int unsigned ROUTE_MODE = 0
) (
    input  logic [COL_ADDR_W-1:0] i_dest_col,
    input  logic [ROW_ADDR_W-1:0] i_dest_row,
    output logic [OUT_M-1:0]      o_sel
);

    localparam logic [COL_ADDR_W-1:0] L_COL = COL_ADDR_W'(COL_CORD);
    localparam logic [ROW_ADDR_W-1:0] L_ROW = ROW_ADDR_W'(ROW_CORD);

    logic                 w_col_gt;
    logic                 w_col_lt;
    logic                 w_row_gt;
    logic                 w_row_lt;
    logic [PORT_ID_W-1:0] w_col_port;
    logic [PORT_ID_W-1:0] w_row_port;
    logic [PORT_ID_W-1:0] w_port;
    logic [PORT_NUM-1:0]  w_onehot;

    assign w_col_gt = (i_dest_col > L_COL);
    assign w_col_lt = (i_dest_col < L_COL);
    assign w_row_gt = (i_dest_row > L_ROW);
    assign w_row_lt = (i_dest_row < L_ROW);

    // Per-dimension decision; RESOURCE when that dimension is already resolved.
    always_comb begin
        w_col_port = PORT_ID_W'(PORT_RESOURCE);
        w_row_port = PORT_ID_W'(PORT_RESOURCE);
        if (w_col_gt) begin
            w_col_port = PORT_ID_W'(PORT_RIGHT);
        end else if (w_col_lt) begin
            w_col_port = PORT_ID_W'(PORT_LEFT);
        end
        if (w_row_lt) begin
            w_row_port = PORT_ID_W'(PORT_NORTH);
        end else if (w_row_gt) begin
            w_row_port = PORT_ID_W'(PORT_SOUTH);
        end
    end

    // First dimension wins whenever it still has distance left.
    always_comb begin
        w_port = w_col_port;
        if (ROUTE_MODE == ROUTE_YX) begin
            w_port = (w_row_gt || w_row_lt) ? w_row_port : w_col_port;
        end else begin
            w_port = (w_col_gt || w_col_lt) ? w_col_port : w_row_port;
        end
    end

    assign w_onehot = PORT_NUM'(1) << w_port;
    assign o_sel    = OUT_M'(w_onehot);

endmodule

// File: rtl/dor_route_unit.sv
// Per-input-port route stage: decodes head flits, holds the route for the packet,
// and registers flit plus one-hot output select in a single pipeline stage.
module dor_route_unit
    import noc_pkg::*;
#(
    parameter int unsigned COL_CORD   = 0,
    parameter int unsigned ROW_CORD   = 0,
    parameter int unsigned COL_ADDR_W = 4,
    parameter int unsigned ROW_ADDR_W = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OUT_M      = 5,
    parameter int unsigned ROUTE_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W+1:0] flit_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W+1:0] flit_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [OUT_M-1:0]  oc_sel_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned FLIT_W = DATA_W + 2;

    rt_state_e          r_state;
    rt_state_e          w_state_nxt;
    logic [OUT_M-1:0]   r_route;
    logic [OUT_M-1:0]   w_route_nxt;
    logic [OUT_M-1:0]   w_calc_sel;
    logic [OUT_M-1:0]   w_sel_nxt;
    logic               w_load;
    logic               w_err_nxt;
    logic               w_accept;
    flit_type_e         w_ftype;

    logic [FLIT_W-1:0]  r_flit;
    logic [OUT_M-1:0]   r_sel;
    logic               r_valid;
    logic               r_err;

    assign w_ftype  = flit_type_e'(flit_i[DATA_W+1:DATA_W]);
    assign ready_o  = !r_valid || ready_i;
    assign w_accept = valid_i && ready_o;

    dor_route_calc #(
        .COL_CORD   (COL_CORD),
        .ROW_CORD   (ROW_CORD),
        .COL_ADDR_W (COL_ADDR_W),
        .ROW_ADDR_W (ROW_ADDR_W),
        .OUT_M      (OUT_M),
        .ROUTE_MODE (ROUTE_MODE)
    ) u_route_calc (
        .i_dest_col (flit_i[COL_ADDR_W-1:0]),
        .i_dest_row (flit_i[COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W]),
        .o_sel      (w_calc_sel)
    );

    // Packet state and held route.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_route <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_route <= w_route_nxt;
        end
    end

    // Next state, route latch and output-register load decision per accepted flit.
    always_comb begin
        w_state_nxt = r_state;
        w_route_nxt = r_route;
        w_sel_nxt   = r_route;
        w_load      = 1'b0;
        w_err_nxt   = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    unique case (w_ftype)
                        FLIT_HEAD: begin
                            w_load      = 1'b1;
                            w_sel_nxt   = w_calc_sel;
                            w_route_nxt = w_calc_sel;
                            w_state_nxt = ST_PKT;
                        end
                        FLIT_SINGLE: begin
                            w_load    = 1'b1;
                            w_sel_nxt = w_calc_sel;
                        end
                        default: begin
                            // Orphan body/tail: drained but dropped.
                            w_err_nxt = 1'b1;
                        end
                    endcase
                end
                ST_PKT: begin
                    w_load = 1'b1;
                    unique case (w_ftype)
                        FLIT_HEAD: begin
                            w_sel_nxt   = w_calc_sel;
                            w_route_nxt = w_calc_sel;
                            w_err_nxt   = 1'b1;
                        end
                        FLIT_SINGLE: begin
                            w_sel_nxt   = w_calc_sel;
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                        FLIT_TAIL: begin
                            w_state_nxt = ST_IDLE;
                        end
                        default: begin
                            w_sel_nxt = r_route;
                        end
                    endcase
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output pipeline register; contents frozen while stalled downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flit  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
            if (w_load) begin
                r_flit  <= flit_i;
                r_sel   <= w_sel_nxt;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign flit_o   = r_flit;
    assign oc_sel_o = r_sel;
    assign valid_o  = r_valid;
    assign err_o    = r_err;
    assign busy_o   = (r_state == ST_PKT);

endmodule

// File: tb/tb_dor_route_unit.sv
// Scoreboard bench for dor_route_unit: an XY and a YX instance at (1,1), stimulated one at a time.
module tb_dor_route_unit;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [4:0] S_RES   = 5'b00001;
    localparam logic [4:0] S_LEFT  = 5'b00010;
    localparam logic [4:0] S_NORTH = 5'b00100;
    localparam logic [4:0] S_RIGHT = 5'b01000;
    localparam logic [4:0] S_SOUTH = 5'b10000;

    typedef struct packed {
        logic [17:0] flit;
        logic [4:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        use_yx;
    logic [17:0] flit_in;
    logic        valid_in;
    logic        ready_dn;

    logic [17:0] w_xy_flit, w_yx_flit;
    logic [4:0]  w_xy_sel, w_yx_sel;
    logic        w_xy_valid, w_yx_valid, w_xy_ready, w_yx_ready;
    logic        w_xy_err, w_yx_err, w_xy_busy, w_yx_busy;

    logic [17:0] o_flit;
    logic [4:0]  o_sel;
    logic        o_valid, o_ready, o_err, o_busy;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dor_route_unit #(
        .COL_CORD(1), .ROW_CORD(1), .COL_ADDR_W(4), .ROW_ADDR_W(4),
        .DATA_W(16), .OUT_M(5), .ROUTE_MODE(0)
    ) dut_xy (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flit_i   (flit_in),
        .valid_i  (valid_in && !use_yx),
        .ready_o  (w_xy_ready),
        .flit_o   (w_xy_flit),
        .valid_o  (w_xy_valid),
        .ready_i  (use_yx ? 1'b1 : ready_dn),
        .oc_sel_o (w_xy_sel),
        .err_o    (w_xy_err),
        .busy_o   (w_xy_busy)
    );

    dor_route_unit #(
        .COL_CORD(1), .ROW_CORD(1), .COL_ADDR_W(4), .ROW_ADDR_W(4),
        .DATA_W(16), .OUT_M(5), .ROUTE_MODE(1)
    ) dut_yx (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flit_i   (flit_in),
        .valid_i  (valid_in && use_yx),
        .ready_o  (w_yx_ready),
        .flit_o   (w_yx_flit),
        .valid_o  (w_yx_valid),
        .ready_i  (use_yx ? ready_dn : 1'b1),
        .oc_sel_o (w_yx_sel),
        .err_o    (w_yx_err),
        .busy_o   (w_yx_busy)
    );

    assign o_flit  = use_yx ? w_yx_flit  : w_xy_flit;
    assign o_sel   = use_yx ? w_yx_sel   : w_xy_sel;
    assign o_valid = use_yx ? w_yx_valid : w_xy_valid;
    assign o_ready = use_yx ? w_yx_ready : w_xy_ready;
    assign o_err   = use_yx ? w_yx_err   : w_xy_err;
    assign o_busy  = use_yx ? w_yx_busy  : w_xy_busy;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [1:0] t, input logic [15:0] p);
        return {t, p};
    endfunction

    // Called at a negedge: drive inputs, score the output transfer due at the next posedge,
    // record the expected output of an accepted flit, then advance one cycle.
    task automatic step(input bit v, input logic [17:0] f, input bit rdy, input bit fwd,
                        input logic [4:0] sel);
        exp_t e;
        valid_in = v;
        flit_in  = f;
        ready_dn = rdy;
        #1;
        if (o_valid && ready_dn) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(o_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("flit", 32'(o_flit), 32'(e.flit));
                chk("sel", 32'(o_sel), 32'(e.sel));
            end
        end
        if (v && o_ready && fwd) begin
            e.flit = f;
            e.sel  = sel;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        logic [17:0] held_flit;
        logic [4:0]  held_sel;

        rst_n    = 1'b0;
        use_yx   = 1'b0;
        valid_in = 1'b0;
        flit_in  = '0;
        ready_dn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_flit",  32'(o_flit),  32'd0);
        chk("rst_sel",   32'(o_sel),   32'd0);
        chk("rst_err",   32'(o_err),   32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SINGLE to local resource
        step(1'b1, mk(T_SINGLE, 16'hA511), 1'b1, 1'b1, S_RES);
        chk("single_valid", 32'(o_valid), 32'd1);
        chk("single_busy",  32'(o_busy),  32'd0);
        idle(1);

        // XY packet to (3,0), back-to-back flits
        step(1'b1, mk(T_HEAD, 16'h5A03), 1'b1, 1'b1, S_RIGHT);
        chk("xy_busy_head", 32'(o_busy), 32'd1);
        step(1'b1, mk(T_BODY, 16'hBEEF), 1'b1, 1'b1, S_RIGHT);
        chk("xy_ready_b0", 32'(o_ready), 32'd1);
        chk("xy_busy_b0",  32'(o_busy),  32'd1);
        step(1'b1, mk(T_BODY, 16'hCAFE), 1'b1, 1'b1, S_RIGHT);
        chk("xy_busy_b1",  32'(o_busy),  32'd1);
        step(1'b1, mk(T_TAIL, 16'h0F0F), 1'b1, 1'b1, S_RIGHT);
        chk("xy_busy_tail", 32'(o_busy), 32'd0);
        chk("xy_err_none",  32'(o_err),  32'd0);
        idle(2);

        // YX instance: (3,0) goes NORTH; a second HEAD to (0,1) goes LEFT with an error
        use_yx = 1'b1;
        step(1'b1, mk(T_HEAD, 16'h7703), 1'b1, 1'b1, S_NORTH);
        chk("yx_busy", 32'(o_busy), 32'd1);
        chk("yx_err0", 32'(o_err),  32'd0);
        step(1'b1, mk(T_HEAD, 16'h6610), 1'b1, 1'b1, S_LEFT);
        chk("yx_err_pulse", 32'(o_err),  32'd1);
        chk("yx_busy2",     32'(o_busy), 32'd1);
        step(1'b1, mk(T_TAIL, 16'h1111), 1'b1, 1'b1, S_LEFT);
        chk("yx_err_clear", 32'(o_err),  32'd0);
        chk("yx_busy_end",  32'(o_busy), 32'd0);
        idle(2);
        use_yx = 1'b0;

        // Backpressure mid-packet, HEAD to (1,0) -> NORTH in XY
        step(1'b1, mk(T_HEAD, 16'h0001), 1'b1, 1'b1, S_NORTH);
        step(1'b1, mk(T_BODY, 16'hB001), 1'b1, 1'b1, S_NORTH);
        held_flit = o_flit;
        held_sel  = o_sel;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(T_BODY, 16'hB002), 1'b0, 1'b1, S_NORTH);
            chk("bp_ready", 32'(o_ready), 32'd0);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_flit",  32'(o_flit),  32'(held_flit));
            chk("bp_sel",   32'(o_sel),   32'(held_sel));
        end
        step(1'b1, mk(T_BODY, 16'hB002), 1'b1, 1'b1, S_NORTH);
        step(1'b1, mk(T_TAIL, 16'hB003), 1'b1, 1'b1, S_NORTH);
        chk("bp_busy_end", 32'(o_busy), 32'd0);
        idle(2);

        // Orphan BODY in IDLE: consumed, not forwarded, one-cycle error
        step(1'b1, mk(T_BODY, 16'h1234), 1'b1, 1'b0, '0);
        chk("orphan_valid", 32'(o_valid), 32'd0);
        chk("orphan_err",   32'(o_err),   32'd1);
        chk("orphan_busy",  32'(o_busy),  32'd0);
        idle(1);
        chk("orphan_err_clr", 32'(o_err), 32'd0);

        // Reset mid-packet abandons the HEAD, then SINGLE to (1,2) goes SOUTH
        step(1'b1, mk(T_HEAD, 16'h0033), 1'b1, 1'b1, S_RIGHT);
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_busy",  32'(o_busy),  32'd0);
        chk("mid_rst_err",   32'(o_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_err", 32'(o_err), 32'd0);
        step(1'b1, mk(T_SINGLE, 16'h0021), 1'b1, 1'b1, S_SOUTH);
        chk("south_valid", 32'(o_valid), 32'd1);
        chk("south_busy",  32'(o_busy),  32'd0);
        idle(3);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
